// File: rtl/sum_squares_pipe.sv
// sum_squares_pipe: pipelined res = a^2 + b^2 + c^2 built from shift-add stages.
// Three identical squaring lanes, each N_STAGES deep. Every lane stage consumes
// B = WIDTH/N_STAGES multiplier bits of the operand. A final stage adds the
// three lane accumulators into res. Latency is N_STAGES+1 registers, and one
// argument set can be accepted every cycle.
// Optional build macro SUM_SQUARES_GATE_EN: data registers load only when
// their incoming valid bit is set, so res holds its last valid value through
// bubbles. Without the macro, data registers load every cycle.
module sum_squares_pipe #(
  parameter int WIDTH    = 16,
  parameter int N_STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arg_vld,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               res_vld,
  output logic [2*WIDTH+1:0] res
);

  localparam int B = WIDTH / N_STAGES;

  logic [WIDTH-1:0]   op     [3];
  logic [WIDTH-1:0]   x_q    [3][N_STAGES-1];
  logic [2*WIDTH-1:0] acc_q  [3][N_STAGES];
  logic [2*WIDTH-1:0] acc_d  [3][N_STAGES];
  logic [2*WIDTH+1:0] sum_d;
  logic [N_STAGES:0]  vld_q;
  logic [N_STAGES:0]  vld_in;
  logic [N_STAGES:0]  ld;

  assign op[0] = a;
  assign op[1] = b;
  assign op[2] = c;

  // Incoming valid for each register stage: index N_STAGES feeds res.
  assign vld_in  = {vld_q[N_STAGES-1:0], arg_vld};
  assign res_vld = vld_q[N_STAGES];

`ifdef SUM_SQUARES_GATE_EN
  assign ld = vld_in;
`else
  assign ld = '1;
`endif

  // Partial products of one stage: B shifted copies of x, selected by x's bits.
  function automatic logic [2*WIDTH-1:0] pp(input logic [WIDTH-1:0] x, input int k);
    logic [2*WIDTH-1:0] s;
    s = '0;
    for (int j = 0; j < B; j++) begin
      if (x[k*B+j]) s = s + ({{WIDTH{1'b0}}, x} << (k*B+j));
    end
    return s;
  endfunction

  // Next accumulator value for every lane stage, plus the final three-way sum.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      acc_d[l][0] = pp(op[l], 0);
      for (int k = 1; k < N_STAGES; k++) begin
        acc_d[l][k] = acc_q[l][k-1] + pp(x_q[l][k-1], k);
      end
    end
    sum_d = {2'b00, acc_q[0][N_STAGES-1]}
          + {2'b00, acc_q[1][N_STAGES-1]}
          + {2'b00, acc_q[2][N_STAGES-1]};
  end

  // Valid shift register; reset flushes every in-flight set.
  always_ff @(posedge clk) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_in;
  end

  // Lane data registers (operand carry and accumulator), never reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (ld[0]) begin
        acc_q[l][0] <= acc_d[l][0];
        x_q[l][0]   <= op[l];
      end
      for (int k = 1; k < N_STAGES; k++) begin
        if (ld[k]) acc_q[l][k] <= acc_d[l][k];
      end
      // The last stage's operand is fully consumed, so it is not carried.
      for (int k = 1; k < N_STAGES-1; k++) begin
        if (ld[k]) x_q[l][k] <= x_q[l][k-1];
      end
    end
  end

  // Result register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst)                res <= '0;
    else if (ld[N_STAGES])   res <= sum_d;
  end

endmodule
